// File: rtl/run_seq_pkg.sv
// Shared types and widths for the ScreamRun frame sequencer.
// Contents:
//   jump_state_t   - jump FSM state (GROUND, ASCEND, DESCEND)
//   COL_W/ROW_W    - VGA counter widths
//   HEIGHT_W       - character height / velocity width
//   SPEED_W        - scroll speed width
//   sat_add_height - unsigned add that clamps at the all-ones height value
package run_seq_pkg;

  localparam int unsigned COL_W    = 12;
  localparam int unsigned ROW_W    = 11;
  localparam int unsigned HEIGHT_W = 10;
  localparam int unsigned SPEED_W  = 4;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2
  } jump_state_t;

  function automatic logic [HEIGHT_W-1:0] sat_add_height(input logic [HEIGHT_W-1:0] a,
                                                         input logic [HEIGHT_W-1:0] b);
    logic [HEIGHT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[HEIGHT_W] ? {HEIGHT_W{1'b1}} : sum[HEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for an asynchronous level input, plus a rising-edge pulse.
// Ports:
//   clock    in  - sampling clock
//   reset    in  - synchronous, active-low reset
//   async_in in  - asynchronous level input
//   level    out - synchronised level
//   rise     out - one-cycle pulse on a rising edge of level
module key_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/run_sequencer.sv
// Per-frame game sequencer: background scroll, speed ramp and jump physics.
// State advances once per frame, at the edge where display_col/display_row are both 0.
// Optional feature macro: RUN_SEQ_DOUBLE_JUMP_EN (one extra mid-air jump per airborne period).
// Ports:
//   clock, reset              - pixel clock, synchronous active-low reset
//   display_col, display_row  - VGA scan position
//   jump_key, pause           - asynchronous user inputs
//   scroll_offset             - background column offset
//   char_height               - character height above ground
//   airborne                  - high when not on the ground
//   speed                     - scroll px/frame
//   frame_tick                - one-cycle pulse when the outputs have just updated
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned JUMP_V0           = 24,
  parameter int unsigned GRAVITY           = 1,
  parameter int unsigned SPEED_MIN         = 1,
  parameter int unsigned SPEED_MAX         = 8,
  parameter int unsigned SPEED_STEP_FRAMES = 600
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [COL_W-1:0]    display_col,
  input  logic [ROW_W-1:0]    display_row,
  input  logic                jump_key,
  input  logic                pause,
  output logic [COL_W-1:0]    scroll_offset,
  output logic [HEIGHT_W-1:0] char_height,
  output logic                airborne,
  output logic [SPEED_W-1:0]  speed,
  output logic                frame_tick
);

  localparam int unsigned StepW = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;

  localparam logic [StepW-1:0]    StepLast = StepW'(SPEED_STEP_FRAMES - 1);
  localparam logic [HEIGHT_W-1:0] V0       = HEIGHT_W'(JUMP_V0);
  localparam logic [HEIGHT_W-1:0] Grav     = HEIGHT_W'(GRAVITY);
  localparam logic [SPEED_W-1:0]  SpeedLo  = SPEED_W'(SPEED_MIN);
  localparam logic [SPEED_W-1:0]  SpeedHi  = SPEED_W'(SPEED_MAX);

  logic jump_rise, jump_level_unused;
  logic pause_level, pause_rise_unused;

  key_edge_sync u_jump_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (jump_key),
    .level    (jump_level_unused),
    .rise     (jump_rise)
  );

  key_edge_sync u_pause_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (pause),
    .level    (pause_level),
    .rise     (pause_rise_unused)
  );

  jump_state_t         state_q;
  logic [HEIGHT_W-1:0] vel_q;
  logic [StepW-1:0]    step_q;
  logic                jump_pending_q;

  logic                frame_start, advance, double_ok;
  logic [HEIGHT_W-1:0] asc_height, asc_vel, desc_vel, desc_height;

  assign frame_start = (display_col == '0) && (display_row == '0);
  assign advance     = frame_start && !pause_level;

  // Physics candidates for the airborne states.
  always_comb begin
    asc_height  = sat_add_height(char_height, vel_q);
    asc_vel     = (vel_q > Grav) ? vel_q - Grav : '0;
    desc_vel    = sat_add_height(vel_q, Grav);
    desc_height = (char_height > desc_vel) ? char_height - desc_vel : '0;
  end

`ifdef RUN_SEQ_DOUBLE_JUMP_EN
  logic used_double_q;

  assign double_ok = jump_pending_q && !used_double_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      used_double_q <= 1'b0;
    end else if (advance) begin
      if (state_q == GROUND) begin
        used_double_q <= 1'b0;
      end else if (double_ok) begin
        used_double_q <= 1'b1;
      end
    end
  end
`else
  assign double_ok = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= GROUND;
      vel_q          <= '0;
      step_q         <= '0;
      jump_pending_q <= 1'b0;
      scroll_offset  <= '0;
      char_height    <= '0;
      airborne       <= 1'b0;
      speed          <= SpeedLo;
      frame_tick     <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      // A rise coinciding with frame start survives into the next frame.
      if (jump_rise) begin
        jump_pending_q <= 1'b1;
      end else if (frame_start) begin
        jump_pending_q <= 1'b0;
      end

      if (advance) begin
        frame_tick    <= 1'b1;
        scroll_offset <= scroll_offset + COL_W'(speed);

        if (step_q == StepLast) begin
          step_q <= '0;
          if (speed < SpeedHi) begin
            speed <= speed + SPEED_W'(1);
          end
        end else begin
          step_q <= step_q + StepW'(1);
        end

        unique case (state_q)
          GROUND: begin
            if (jump_pending_q) begin
              state_q  <= ASCEND;
              vel_q    <= V0;
              airborne <= 1'b1;
            end
          end
          ASCEND: begin
            if (double_ok) begin
              vel_q <= V0;
            end else begin
              char_height <= asc_height;
              vel_q       <= asc_vel;
              if (asc_vel == '0) begin
                state_q <= DESCEND;
              end
            end
          end
          DESCEND: begin
            if (double_ok) begin
              state_q <= ASCEND;
              vel_q   <= V0;
            end else begin
              char_height <= desc_height;
              vel_q       <= desc_vel;
              if (desc_height == '0) begin
                state_q  <= GROUND;
                vel_q    <= '0;
                airborne <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= GROUND;
            vel_q    <= '0;
            airborne <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
